maxnet_arbiter: RTL and testbench
=================================

MAXNET_ARBITER -- requirements
Module: maxnet_arbiter

Interface
REQ-001 Parameter MAX_ITER, default 64: maximum ITER cycles allowed per job before abort.
REQ-002 Parameter DW, default 32: width of the datapath result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 job request, level; held until done0.
REQ-006 req1  input  1  requester 1 job request, level; held until done1.
REQ-007 gnt0  output  1  requester 0 owns the engine (LOAD through RESP).
REQ-008 gnt1  output  1  requester 1 owns the engine (LOAD through RESP).
REQ-009 done0  output  1  one-cycle pulse: requester 0 job complete, result valid.
REQ-010 done1  output  1  one-cycle pulse: requester 1 job complete, result valid.
REQ-011 err  output  1  high with the done pulse when the job timed out.
REQ-012 result  output  DW  last captured result, held until the next capture.
REQ-013 load_a  output  1  datapath register load enable.
REQ-014 load_sel  output  1  datapath input select: 0 = initial values, 1 = iteration update.
REQ-015 is_finished  input  1  datapath reports a single winner remaining.
REQ-016 dp_res  input  DW  datapath winner value.

Function
REQ-017 FSM states: IDLE, LOAD, ITER, RESP; state register only.
REQ-018 IDLE: on req0|req1, pick the owner, register it, go to LOAD next cycle; otherwise stay.
REQ-019 Pick rule: a single request wins; if both request, the requester not granted last wins; last-owner register resets to 1, so req0 wins the first tie.
REQ-020 LOAD lasts exactly one cycle: load_a=1, load_sel=0, iteration counter cleared; then go to ITER.
REQ-021 ITER: load_a = ~is_finished and load_sel=1 (combinational); counter increments each ITER cycle.
REQ-022 ITER with is_finished=1: capture dp_res into result, err=0, go to RESP.
REQ-023 ITER with is_finished=0 and counter==MAX_ITER-1: result<=0, err<=1, go to RESP (timeout).
REQ-024 RESP lasts exactly one cycle: done of the owner =1, err valid; then go to IDLE.
REQ-025 gnt of the owner is high in LOAD, ITER and RESP; gnt0 and gnt1 are never both high.
REQ-026 Minimum latency: req sampled at edge 0, LOAD in cycle 1, ITER in cycle 2 (is_finished=1), done in cycle 3.
REQ-027 A request dropped mid-job is ignored: the job completes and done still pulses.
REQ-028 In RESP, new requests are not sampled; re-arbitration happens only in IDLE, so there is at least one idle cycle between jobs.
REQ-029 Counter width is $clog2(MAX_ITER+1); the counter never wraps within a job.
REQ-030 load_a=0 and load_sel=0 in IDLE and RESP.

Reset
REQ-031 rst=1 at an edge forces IDLE, counter 0, last-owner 1, result 0, err 0; gnt*, done*, load_a and load_sel are 0 in the following cycle.
REQ-032 Reset mid-job aborts the job with no done pulse; rst has priority over every transition.

Structure
REQ-033 A shared package holds the state enum, the MAX_ITER default and the DW default.
REQ-034 One sub-module, maxnet_rr_arb, implements the 2-way round-robin pick and the last-owner register.
REQ-035 The maxnet datapath is instantiated outside this block and connects via load_a, load_sel, is_finished and dp_res.

Verification
REQ-036 req0 only; model sets is_finished=1 on the 4th ITER cycle with dp_res=32'h0000_0042 -> one LOAD cycle, 4 ITER cycles, done0 pulse, result=0x42, err=0, gnt1 never high.
REQ-037 req0 and req1 both high from reset; each job finishes after 2 ITER cycles -> order is req0 then req1; a third job with both still requesting goes to req0; done pulses alternate.
REQ-038 is_finished held 0 with MAX_ITER=8 -> exactly 8 ITER cycles, then done pulse with err=1 and result=0; next job clears err.
REQ-039 rst asserted during the 3rd ITER cycle -> next cycle IDLE, all outputs 0, no done pulse; a new req1 is then served normally.
REQ-040 req1 dropped after LOAD -> job completes and done1 still pulses; is_finished=1 in the first ITER cycle -> done in cycle 3 after req.

Source files
------------

// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_pkg
// Purpose  : Shared FSM state encoding and default sizes for the maxnet arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package maxnet_pkg;

    localparam int c_max_iter_default = 64;
    localparam int c_dw_default       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/maxnet_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_rr_arb
// Purpose  : Two-way round-robin pick; the last-owner register is the owner.
// Revision : 1.0 - initial release
// ============================================================================
module maxnet_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic arb_en,
    output logic owner
);

    logic r_last;
    logic w_pick;

    // On a tie the requester not granted last wins; reset value 1 favours req0.
    assign w_pick = (req0 && req1) ? ~r_last : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (arb_en && (req0 || req1)) begin
            r_last <= w_pick;
        end
    end

    assign owner = r_last;

endmodule
`default_nettype wire

// File: rtl/maxnet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_arbiter
// Purpose  : Shares one maxnet datapath between two requesters, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module maxnet_arbiter
    import maxnet_pkg::*;
#(
    parameter int MAX_ITER = c_max_iter_default,
    parameter int DW       = c_dw_default
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [DW-1:0] result,
    output logic          load_a,
    output logic          load_sel,
    input  logic          is_finished,
    input  logic [DW-1:0] dp_res
);

    localparam int                 c_cnt_w    = $clog2(MAX_ITER + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_ITER - 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DW-1:0]        r_result;
    logic                 r_err;
    logic                 w_owner;
    logic                 w_arb_en;
    logic                 w_timeout;

    maxnet_rr_arb u_rr_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .arb_en (w_arb_en),
        .owner  (w_owner)
    );

    assign w_timeout = (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_arb_en = 1'b0;
        load_a   = 1'b0;
        load_sel = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb_en = 1'b1;
                if (req0 || req1) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_a = 1'b1;
                w_next = ST_ITER;
            end
            ST_ITER: begin
                load_a   = ~is_finished;
                load_sel = 1'b1;
                if (is_finished || w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                done0  = ~w_owner;
                done1  = w_owner;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (r_state != ST_IDLE) begin
            gnt0 = ~w_owner;
            gnt1 = w_owner;
        end
    end

    // Counter holds the number of ITER cycles already completed in this job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: r_cnt <= '0;
                ST_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (is_finished) begin
                        r_result <= dp_res;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxnet_arbiter
// Purpose  : Directed self-checking bench for maxnet_arbiter (MAX_ITER = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxnet_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [31:0] result;
    logic        load_a, load_sel;
    logic        is_finished;
    logic [31:0] dp_res;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    maxnet_arbiter #(.MAX_ITER(8), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .err         (err),
        .result      (result),
        .load_a      (load_a),
        .load_sel    (load_sel),
        .is_finished (is_finished),
        .dp_res      (dp_res)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in IDLE with the request already driven; returns in the following IDLE cycle.
    task automatic run_job(input logic own, input int n, input logic fin,
                           input logic [31:0] dp, input logic exp_err,
                           input logic [31:0] exp_res, input logic drop);
        logic [1:0] g;
        g = own ? 2'b10 : 2'b01;
        step();
        chk("load_gnt", {gnt1, gnt0}, g);
        chk("load_ctl", {load_a, load_sel, done1, done0}, 4'b1000);
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        for (int k = 1; k <= n; k++) begin
            step();
            is_finished = fin && (k == n);
            dp_res      = is_finished ? dp : 32'hDEAD_BEEF;
            #1;
            chk("iter_gnt", {gnt1, gnt0}, g);
            chk("iter_ctl", {load_a, load_sel, done1, done0}, {~is_finished, 3'b100});
        end
        step();
        is_finished = 1'b0;
        chk("resp_gnt", {gnt1, gnt0}, g);
        chk("resp_done", {done1, done0}, g);
        chk("resp_ctl", {load_a, load_sel}, 2'b00);
        chk("resp_err", err, exp_err);
        chk("resp_result", result, exp_res);
        step();
        chk("idle_out", {gnt1, gnt0, done1, done0, load_a, load_sel}, 6'b0);
        chk("idle_result", result, exp_res);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out", {gnt1, gnt0, done1, done0, load_a, load_sel, err}, 7'b0);
        chk("rst_result", result, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        req0        = 1'b0;
        req1        = 1'b0;
        is_finished = 1'b0;
        dp_res      = 32'h0;
        do_reset();

        // Single requester, finishes on 4th ITER cycle.
        req0 = 1'b1;
        run_job(1'b0, 4, 1'b1, 32'h0000_0042, 1'b0, 32'h0000_0042, 1'b0);
        req0 = 1'b0;

        // Both requesting from reset: 0, 1, 0.
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        run_job(1'b0, 2, 1'b1, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b0);
        run_job(1'b1, 2, 1'b1, 32'h0000_005A, 1'b0, 32'h0000_005A, 1'b0);
        run_job(1'b0, 2, 1'b1, 32'h0000_0033, 1'b0, 32'h0000_0033, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;

        // Timeout after exactly 8 ITER cycles, then a clean job clears err.
        req1 = 1'b1;
        run_job(1'b1, 8, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("err_held_idle", err, 1'b1);
        run_job(1'b1, 1, 1'b1, 32'h0000_0077, 1'b0, 32'h0000_0077, 1'b0);

        // Reset during 3rd ITER cycle aborts with no done pulse.
        step();
        chk("abort_load", {gnt1, gnt0, load_a}, 3'b101);
        step();
        step();
        step();
        chk("abort_iter3", {gnt1, gnt0, load_a, load_sel}, 4'b1011);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out", {gnt1, gnt0, done1, done0, load_a, load_sel, err}, 7'b0);
        chk("abort_result", result, 32'h0);
        run_job(1'b1, 1, 1'b1, 32'h0000_0011, 1'b0, 32'h0000_0011, 1'b0);
        req1 = 1'b0;
        step();
        chk("idle_quiet", {gnt1, gnt0, done1, done0}, 4'b0);

        // req1 dropped after LOAD; finish in first ITER cycle.
        req1 = 1'b1;
        run_job(1'b1, 1, 1'b1, 32'h0000_0099, 1'b0, 32'h0000_0099, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
